ad7606_emu: RTL and testbench

Synthesizable device-side model of the AD7606 parallel interface. It is the responder to the AD7606 controller and sits in the loopback/self-test build in place of the physical ADC. It answers CONVST with a BUSY pulse whose length scales with oversampling, then returns eight latched 16-bit channel words on successive CS/RD strobes, with FRSTDATA marking channel 1. All inputs are synchronous to the controller's 50 MHz clock.

---
 rtl/ad7606_emu.sv | 146 ++++++++++++++
 tb/tb_ad7606_emu.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ad7606_emu.sv
// Device-side stand-in for the AD7606 parallel interface: CONVST -> BUSY of
// oversampling-scaled length, then eight latched channel words read out on CS/RD strobes.
module ad7606_emu #(
    parameter int CONV_CYCLES = 200,
    parameter int CNT_W       = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cvtA,
    input  logic         cvtB,
    input  logic         cs,
    input  logic         rd,
    input  logic         range,
    input  logic         phy_rst,
    input  logic [2:0]   os,
    input  logic [127:0] sample_in,
    output logic         busy,
    output logic         fdata,
    output logic [15:0]  data_out,
    output logic         rd_err
);

    // state | meaning
    // IDLE  | no conversion since reset; reads ignored
    // CONV  | conversion running, BUSY high; reads flagged as errors
    // READ  | results latched; each RD fall returns the next channel
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        READ = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       ch_ptr, ch_ptr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [15:0]      shadow     [8];
    logic [15:0]      shadow_nxt [8];
    logic             range_lat, range_lat_nxt;
    logic             busy_nxt, fdata_nxt, rd_err_nxt;
    logic [15:0]      data_nxt;
    logic             cvt_q, rd_q;
    logic             cvt_both, start, rd_fall;
    logic [2:0]       os_eff;
    logic [15:0]      ch_word;

    assign cvt_both = cvtA & cvtB;
    assign start    = cvt_both & ~cvt_q;
    assign rd_fall  = ~rd & rd_q & ~cs;
    assign os_eff   = (os == 3'd7) ? 3'd0 : os;

    always_comb begin
        state_nxt     = state;
        ch_ptr_nxt    = ch_ptr;
        cnt_nxt       = cnt;
        range_lat_nxt = range_lat;
        busy_nxt      = busy;
        fdata_nxt     = fdata;
        data_nxt      = data_out;
        rd_err_nxt    = 1'b0;
        ch_word       = '0;
        for (int i = 0; i < 8; i++) begin
            shadow_nxt[i] = shadow[i];
        end

        if (phy_rst) begin
            state_nxt     = IDLE;
            ch_ptr_nxt    = '0;
            cnt_nxt       = '0;
            range_lat_nxt = 1'b0;
            busy_nxt      = 1'b0;
            fdata_nxt     = 1'b0;
            data_nxt      = '0;
            for (int i = 0; i < 8; i++) begin
                shadow_nxt[i] = '0;
            end
        end else if (start && state != CONV) begin
            // a start in READ also beats a coincident read strobe
            state_nxt     = CONV;
            cnt_nxt       = (CNT_W'(CONV_CYCLES) << os_eff) - CNT_W'(1);
            range_lat_nxt = range;
            ch_ptr_nxt    = '0;
            fdata_nxt     = 1'b0;
            busy_nxt      = 1'b1;
        end else begin
            case (state)
                CONV: begin
                    if (rd_fall) begin
                        rd_err_nxt = 1'b1;
                    end
                    if (cnt == '0) begin
                        busy_nxt  = 1'b0;
                        state_nxt = READ;
                        for (int i = 0; i < 8; i++) begin
                            ch_word       = sample_in[i*16 +: 16];
                            shadow_nxt[i] = range_lat ? {ch_word[15], ch_word[15:1]} : ch_word;
                        end
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                READ: begin
                    if (rd_fall) begin
                        data_nxt   = shadow[ch_ptr];
                        fdata_nxt  = (ch_ptr == 3'd0);
                        ch_ptr_nxt = ch_ptr + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ch_ptr    <= '0;
            cnt       <= '0;
            range_lat <= 1'b0;
            busy      <= 1'b0;
            fdata     <= 1'b0;
            data_out  <= '0;
            rd_err    <= 1'b0;
            cvt_q     <= 1'b0;
            rd_q      <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            ch_ptr    <= ch_ptr_nxt;
            cnt       <= cnt_nxt;
            range_lat <= range_lat_nxt;
            busy      <= busy_nxt;
            fdata     <= fdata_nxt;
            data_out  <= data_nxt;
            rd_err    <= phy_rst ? 1'b0 : rd_err_nxt;
            cvt_q     <= phy_rst ? 1'b0 : cvt_both;
            rd_q      <= phy_rst ? 1'b0 : rd;
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= shadow_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_ad7606_emu.sv
// Directed bench for ad7606_emu: busy length vs oversampling, channel readout,
// range halving, read-while-busy errors and reset behaviour.
module tb_ad7606_emu;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cvtA, cvtB, cs, rd, range, phy_rst;
    logic [2:0]   os;
    logic [127:0] sample_in;
    logic         busy, fdata, rd_err;
    logic [15:0]  data_out;

    int total = 0;
    int bad   = 0;
    int hi_cnt = 0;
    int seen_out = 0;
    int base;
    logic [15:0] d;
    logic        f, e;

    always #10 clk = ~clk;

    ad7606_emu dut (
        .clk(clk), .rst_n(rst_n), .cvtA(cvtA), .cvtB(cvtB), .cs(cs), .rd(rd),
        .range(range), .phy_rst(phy_rst), .os(os), .sample_in(sample_in),
        .busy(busy), .fdata(fdata), .data_out(data_out), .rd_err(rd_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // every wait goes through here so busy-high cycles are counted in one place
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy) hi_cnt++;
            if (data_out != 16'h0 || fdata) seen_out++;
        end
    endtask

    task automatic start_conv();
        cvtA = 1'b1;
        cvtB = 1'b1;
        tick(1);
        check("busy_rise", busy, 1);
        cvtA = 1'b0;
        cvtB = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy && guard < 6000) begin
            tick(1);
            guard++;
        end
        check("busy_low", busy, 0);
    endtask

    task automatic read_strobe(output logic [15:0] dv, output logic fv, output logic ev);
        cs = 1'b0;
        rd = 1'b0;
        tick(1);
        ev = rd_err;
        rd = 1'b1;
        cs = 1'b1;
        tick(1);
        dv = data_out;
        fv = fdata;
    endtask

    task automatic set_ramp();
        for (int i = 0; i < 8; i++) sample_in[i*16 +: 16] = 16'(i + 1);
    endtask

    task automatic conv_len(input logic [2:0] os_start, input logic [2:0] os_mid,
                            input logic [31:0] exp, input string tag);
        os = os_start;
        base = hi_cnt;
        start_conv();
        os = os_mid;
        wait_idle();
        check(tag, hi_cnt - base, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        cvtA = 0; cvtB = 0; cs = 1; rd = 1; range = 0; phy_rst = 0; os = 3'd0;
        set_ramp();
        tick(3);
        check("rst_busy", busy, 0);
        check("rst_fdata", fdata, 0);
        check("rst_data", data_out, 0);
        check("rst_rd_err", rd_err, 0);
        rst_n = 1'b1;
        tick(2);

        phy_rst = 1'b1;
        tick(2);
        phy_rst = 1'b0;
        tick(1);
        check("phy_busy", busy, 0);

        // base conversion, outputs must stay quiet
        seen_out = 0;
        conv_len(3'd0, 3'd0, 200, "len_os0");
        check("quiet_during_conv", seen_out, 0);

        for (int i = 0; i < 8; i++) begin
            read_strobe(d, f, e);
            check("ramp_data", d, 16'(i + 1));
            check("ramp_fdata", f, (i == 0));
        end
        read_strobe(d, f, e);
        check("wrap_data", d, 16'h0001);
        check("wrap_fdata", f, 1);

        range = 1'b1;
        sample_in[15:0]  = 16'h8000;
        sample_in[31:16] = 16'h7FFF;
        sample_in[47:32] = 16'hFFFF;
        conv_len(3'd0, 3'd0, 200, "len_range");
        range = 1'b0;
        read_strobe(d, f, e);
        check("rng_ch1", d, 16'hC000);
        check("rng_ch1_f", f, 1);
        read_strobe(d, f, e);
        check("rng_ch2", d, 16'h3FFF);
        read_strobe(d, f, e);
        check("rng_ch3", d, 16'hFFFF);
        check("rng_ch3_f", f, 0);

        conv_len(3'd3, 3'd3, 1600, "len_os3");
        conv_len(3'd7, 3'd7, 200, "len_os7");
        conv_len(3'd0, 3'd3, 200, "len_os_mid");

        // second CONVST during busy must not extend it
        os = 3'd0;
        base = hi_cnt;
        start_conv();
        tick(50);
        start_conv();
        wait_idle();
        check("len_restart", hi_cnt - base, 200);

        // read while busy: error pulse, output untouched
        set_ramp();
        start_conv();
        tick(10);
        cs = 1'b0;
        rd = 1'b0;
        tick(1);
        check("err_pulse", rd_err, 1);
        check("err_data", data_out, 16'hFFFF);
        check("err_fdata", fdata, 0);
        rd = 1'b1;
        cs = 1'b1;
        tick(1);
        check("err_clear", rd_err, 0);
        wait_idle();
        read_strobe(d, f, e);
        check("after_err_data", d, 16'h0001);
        check("after_err_f", f, 1);

        // start and read fall together in READ: start wins
        cvtA = 1'b1; cvtB = 1'b1; cs = 1'b0; rd = 1'b0;
        tick(1);
        check("tie_busy", busy, 1);
        check("tie_rd_err", rd_err, 0);
        check("tie_data", data_out, 16'h0001);
        cvtA = 1'b0; cvtB = 1'b0; cs = 1'b1; rd = 1'b1;
        wait_idle();
        read_strobe(d, f, e);
        check("tie_read_data", d, 16'h0001);
        check("tie_read_f", f, 1);
        read_strobe(d, f, e);
        check("tie_read2", d, 16'h0002);

        // rd held low across conversion end yields no read
        start_conv();
        tick(5);
        cs = 1'b0;
        rd = 1'b0;
        wait_idle();
        tick(5);
        check("hold_data", data_out, 16'h0002);
        check("hold_fdata", fdata, 0);
        rd = 1'b1;
        cs = 1'b1;
        tick(1);
        read_strobe(d, f, e);
        check("hold_next", d, 16'h0001);
        check("hold_next_f", f, 1);

        // only one CONVST rising: no conversion
        cvtA = 1'b1;
        tick(3);
        check("single_cvt", busy, 0);
        cvtA = 1'b0;
        tick(1);

        // async reset mid-conversion
        start_conv();
        tick(30);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_data", data_out, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        read_strobe(d, f, e);
        check("idle_read_data", d, 0);
        check("idle_read_f", f, 0);
        check("idle_read_err", e, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
